// File: rtl/data_path_gen.sv
// Parametrised accumulator data path: PC/IR/R0/MR/ACC registers, 8-op ALU with
// registered Z/N/C flags, and an iterative shift-add multiplier writing into ACC.
module data_path_gen #(
  parameter int WIDTH  = 16,
  parameter int OPC_W  = 4,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  int_rbus,
  input  logic [1:0]        pc_op,
  input  logic              ir_ld,
  input  logic              r0_ld,
  input  logic              mr_ld,
  input  logic [1:0]        acc_sel,
  input  logic [2:0]        alu_op,
  input  logic              abus_sel,
  input  logic              wbus_en,
  input  logic              mul_start,
  output logic [OPC_W-1:0]  IR,
  output logic [WIDTH-1:0]  int_abus,
  output logic [WIDTH-1:0]  int_wbus,
  output logic              Z,
  output logic              N,
  output logic              C,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  generate
    if ((OPC_W + ADDR_W > WIDTH) || (ADDR_W > WIDTH)) begin : g_bad_params
      $error("data_path_gen: opcode and address fields do not fit in WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] pc_q, pc_d, r0_q, r0_d, mr_q, mr_d, acc_q, acc_d;
  logic [OPC_W-1:0] ir_q, ir_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   alu_full;   // {carry, result}
  logic [WIDTH-1:0] step_prod;

  always_comb begin
    alu_full = '0;
    case (alu_op)
      3'b000:  alu_full = {1'b0, acc_q} + {1'b0, r0_q};
      3'b001:  alu_full = {1'b0, acc_q} + {1'b0, ~r0_q} + (WIDTH+1)'(1);
      3'b010:  alu_full = {1'b0, acc_q & r0_q};
      3'b011:  alu_full = {1'b0, acc_q | r0_q};
      3'b100:  alu_full = {1'b0, acc_q ^ r0_q};
      3'b101:  alu_full = {1'b0, r0_q};
      3'b110:  alu_full = {acc_q[WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
      default: alu_full = {acc_q[0], 1'b0, acc_q[WIDTH-1:1]};
    endcase
  end

  assign step_prod = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    pc_d = pc_q;
    case (pc_op)
      2'b01:   pc_d = '0;
      2'b10:   pc_d = pc_q + WIDTH'(1);
      2'b11:   pc_d = r0_q;
      default: pc_d = pc_q;
    endcase
    ir_d     = ir_ld ? int_rbus[WIDTH-1 -: OPC_W] : ir_q;
    r0_d     = r0_ld ? WIDTH'(int_rbus[ADDR_W-1:0]) : r0_q;
    mr_d     = mr_ld ? r0_q : mr_q;
    acc_d    = acc_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    if (busy_q) begin
      // ACC is owned by the multiplier while busy; acc_sel and mul_start are ignored.
      prod_d   = step_prod;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        acc_d  = step_prod;
        z_d    = (step_prod == '0);
        n_d    = step_prod[WIDTH-1];
        c_d    = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else begin
      if (acc_sel == 2'b01) begin
        acc_d = int_rbus;
      end else if (acc_sel == 2'b10) begin
        acc_d = alu_full[WIDTH-1:0];
        z_d   = (alu_full[WIDTH-1:0] == '0);
        n_d   = alu_full[WIDTH-1];
        c_d   = alu_full[WIDTH];
      end
      if (mul_start) begin
        mcand_d  = acc_q;
        mplier_d = r0_q;
        prod_d   = '0;
        cnt_d    = CNT_W'(WIDTH);
        busy_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      ir_q     <= '0;
      r0_q     <= '0;
      mr_q     <= '0;
      acc_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      r0_q     <= r0_d;
      mr_q     <= mr_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign IR       = ir_q;
  assign int_abus = abus_sel ? mr_q : pc_q;
  assign int_wbus = wbus_en ? acc_q : '0;
  assign Z        = z_q;
  assign N        = n_q;
  assign C        = c_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
